// File: rtl/vcve2_rvfi_trace_buf_if.sv
// Bus bundle between vcve2_top's RVFI retirement outputs, the trace buffer and its drain port.
// The master is the core/bridge side. The slave is the trace buffer.
interface vcve2_rvfi_trace_buf_if #(
  parameter bit CaptureMem = 1'b0
);
  localparam int unsigned RecW = 102 + (CaptureMem ? 40 : 0);

  logic            rvfi_valid;
  logic [31:0]     rvfi_pc_rdata;
  logic [31:0]     rvfi_insn;
  logic            rvfi_trap;
  logic [4:0]      rvfi_rd_addr;
  logic [31:0]     rvfi_rd_wdata;
  logic [31:0]     rvfi_mem_addr;
  logic [3:0]      rvfi_mem_rmask;
  logic [3:0]      rvfi_mem_wmask;
  logic            rd_valid;
  logic            rd_ready;
  logic [RecW-1:0] rd_data;

  modport master (
    output rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_trap, rvfi_rd_addr, rvfi_rd_wdata,
           rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_trap, rvfi_rd_addr, rvfi_rd_wdata,
           rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rd_ready,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/vcve2_rvfi_trace_buf.sv
// On-chip RVFI trace capture: circular record buffer with PC trigger, post-trigger count,
// wrap/stop-on-full modes and drop accounting, drained over a valid/ready port.
//
// state   | meaning
// IDLE    | no session since reset, nothing captured
// ARMED   | waiting for a retirement at trig_pc_i
// CAPTURE | recording every retirement
// DONE    | session ended, buffer readable, no capture
module vcve2_rvfi_trace_buf #(
  parameter int unsigned Depth      = 16,
  parameter bit          CaptureMem = 1'b0,
  localparam int unsigned RecW      = 102 + (CaptureMem ? 40 : 0),
  localparam int unsigned CntW      = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  vcve2_rvfi_trace_buf_if.slave bus,
  input  logic                 arm_i,
  input  logic                 stop_i,
  input  logic                 wrap_mode_i,
  input  logic                 trig_en_i,
  input  logic [31:0]          trig_pc_i,
  input  logic [15:0]          post_cnt_i,
  output logic [CntW-1:0]      count_o,
  output logic [1:0]           state_o,
  output logic                 overflow_o,
  output logic [15:0]          drop_cnt_o
);
  localparam int unsigned AW = $clog2(Depth);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic            wrap_q, wrap_d, limited_q, limited_d;
  logic [15:0]     remain_q, remain_d;
  logic [RecW-1:0] mem_q [Depth];
  logic [RecW-1:0] rec;
  logic            full, pop, capture, push_store, overwrite, drop, we;

  if (CaptureMem) begin : g_mem_rec
    assign rec = {bus.rvfi_mem_addr, bus.rvfi_mem_rmask, bus.rvfi_mem_wmask, bus.rvfi_trap,
                  bus.rvfi_rd_addr, bus.rvfi_rd_wdata, bus.rvfi_insn, bus.rvfi_pc_rdata};
  end else begin : g_base_rec
    logic unused_mem;
    assign unused_mem = ^{bus.rvfi_mem_addr, bus.rvfi_mem_rmask, bus.rvfi_mem_wmask};
    assign rec = {bus.rvfi_trap, bus.rvfi_rd_addr, bus.rvfi_rd_wdata, bus.rvfi_insn,
                  bus.rvfi_pc_rdata};
  end

  assign full = (count_q == CntW'(Depth));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    wrap_d     = wrap_q;
    limited_d  = limited_q;
    remain_d   = remain_q;
    pop        = 1'b0;
    capture    = 1'b0;
    push_store = 1'b0;
    overwrite  = 1'b0;
    drop       = 1'b0;
    we         = 1'b0;

    if (arm_i) begin
      // Flush wins over everything, including a pop in flight on the read port.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
      wrap_d     = wrap_mode_i;
      limited_d  = (post_cnt_i != 16'd0);
      remain_d   = post_cnt_i;
      state_d    = trig_en_i ? ST_ARMED : ST_CAPTURE;
    end else begin
      pop = (count_q != '0) && bus.rd_ready;
      if (stop_i && (state_q == ST_ARMED || state_q == ST_CAPTURE)) begin
        state_d = ST_DONE;
      end else begin
        capture = bus.rvfi_valid &&
                  ((state_q == ST_CAPTURE) ||
                   (state_q == ST_ARMED && bus.rvfi_pc_rdata == trig_pc_i));
      end

      if (capture) begin
        if (state_q == ST_ARMED) state_d = ST_CAPTURE;
        // Dropped records still consume the post-trigger budget.
        if (limited_q) begin
          if (remain_q == 16'd1) state_d = ST_DONE;
          remain_d = remain_q - 16'd1;
        end
      end

      push_store = capture && (!full || pop || wrap_q);
      overwrite  = capture && full && !pop && wrap_q;
      drop       = capture && full && !pop;
      we         = push_store;

      if (push_store) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop || overwrite) rd_ptr_d = rd_ptr_q + AW'(1);

      if (push_store && !pop && !overwrite) count_d = count_q + CntW'(1);
      else if (pop && !push_store)          count_d = count_q - CntW'(1);

      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      wrap_q     <= 1'b0;
      limited_q  <= 1'b0;
      remain_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      wrap_q     <= wrap_d;
      limited_q  <= limited_d;
      remain_q   <= remain_d;
    end
  end

  // Storage is not reset; an empty buffer presents zero instead of stale contents.
  always_ff @(posedge clk_i) begin
    if (we) mem_q[wr_ptr_q] <= rec;
  end

  assign bus.rd_valid = (count_q != '0);
  assign bus.rd_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o      = count_q;
  assign state_o      = state_q;
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_cnt_q;
endmodule
